// File: rtl/add_sub_pkg.sv
// Shared definitions for the pipelined adder-subtractor: op modes,
// chunk sizing and the signed saturation constant.
package add_sub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  localparam int MAX_WIDTH = 64;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Largest positive (negative = 0) or most negative (negative = 1) value;
  // callers cast the result down to their own width.
  function automatic logic [MAX_WIDTH-1:0] sat_value(input int width, input logic negative);
    logic [MAX_WIDTH-1:0] msb_only;
    msb_only = MAX_WIDTH'(1) << (width - 1);
    return negative ? msb_only : msb_only - 1'b1;
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit ripple adder with operand-B inversion for subtract;
// exposes the carry into its MSB so the top can derive signed overflow.
module add_sub_chunk
  import add_sub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] b_x;
  logic [CHUNK:0]   carry;

  assign b_x      = (sub == SUB) ? ~b : b;
  assign carry[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign sum[gi]      = a[gi] ^ b_x[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b_x[gi]) | (carry[gi] & (a[gi] ^ b_x[gi]));
  end

  assign cout  = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub: one CHUNK per stage, carries registered
// between stages, whole-pipeline stall on output backpressure.
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  // Stage k register: acc holds finished result chunks below k and raw A above.
  logic             v_reg   [STAGES];
  logic [WIDTH-1:0] acc_reg [STAGES];
  logic [WIDTH-1:0] b_reg   [STAGES];
  logic             sub_reg [STAGES];
  logic             sat_reg [STAGES];
  logic             c_reg   [STAGES];

  logic [CHUNK-1:0] sum_w [STAGES];
  logic             co_w  [STAGES];
  logic             cm_w  [STAGES];

  logic             adv;
  logic [WIDTH-1:0] raw_next;
  logic [WIDTH-1:0] sat_next;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (acc_reg[gi][gi*CHUNK +: CHUNK]),
      .b     (b_reg[gi][gi*CHUNK +: CHUNK]),
      .sub   (sub_reg[gi]),
      .cin   (c_reg[gi]),
      .sum   (sum_w[gi]),
      .cout  (co_w[gi]),
      .c_msb (cm_w[gi])
    );
  end

  always_comb begin
    raw_next = acc_reg[LAST];
    raw_next[LAST*CHUNK +: CHUNK] = sum_w[LAST];
    ovf_next = co_w[LAST] ^ cm_w[LAST];
    // A's sign still sits in the top chunk, and it is the sign of the true result on overflow.
    sat_next = WIDTH'(sat_value(WIDTH, acc_reg[LAST][WIDTH-1]));
    res_next = (sat_reg[LAST] && ovf_next) ? sat_next : raw_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_reg[k]   <= 1'b0;
        acc_reg[k] <= '0;
        b_reg[k]   <= '0;
        sub_reg[k] <= 1'b0;
        sat_reg[k] <= 1'b0;
        c_reg[k]   <= 1'b0;
      end
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      v_reg[0]   <= in_valid;
      acc_reg[0] <= a;
      b_reg[0]   <= b;
      sub_reg[0] <= sub;
      sat_reg[0] <= sat;
      c_reg[0]   <= sub;
      for (int k = 0; k < LAST; k++) begin
        v_reg[k+1]   <= v_reg[k];
        acc_reg[k+1] <= acc_reg[k];
        acc_reg[k+1][k*CHUNK +: CHUNK] <= sum_w[k];
        b_reg[k+1]   <= b_reg[k];
        sub_reg[k+1] <= sub_reg[k];
        sat_reg[k+1] <= sat_reg[k];
        c_reg[k+1]   <= co_w[k];
      end
      out_valid <= v_reg[LAST];
      result    <= res_next;
      cout      <= co_w[LAST];
      overflow  <= ovf_next;
      zero      <= (res_next == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed-vector bench for pipelined_add_sub at 8/2, 32/4 and 8/1, with
// per-instance scoreboards and hand-written reset/backpressure sequences.
module tb_pipelined_add_sub;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       sat;
    logic [7:0] r;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
    int          stamp;
    bit          chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        sat = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        in_ready0, out_valid0, cout0, overflow0, zero0;
  logic [7:0]  result0;
  logic        in_ready1, out_valid1, cout1, overflow1, zero1;
  logic [31:0] result1;
  logic        in_ready2, out_valid2, cout2, overflow2, zero2;
  logic [7:0]  result2;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   lat_on = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pipelined_add_sub #(.WIDTH(8), .STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .sat(sat),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
    .cout(cout0), .overflow(overflow0), .zero(zero0));

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .sat(sat),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .cout(cout1), .overflow(overflow1), .zero(zero1));

  pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .sat(sat),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
    .cout(cout2), .overflow(overflow2), .zero(zero2));

  function automatic void cmp(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endfunction

  // Reference: plain integer arithmetic on a 33-bit sum, signs compared directly.
  function automatic exp_t model(int w, logic [31:0] aa, logic [31:0] bb, logic s, logic st);
    exp_t        m;
    logic [32:0] full;
    logic [31:0] mask, bx, sm;
    logic        sa, sb, ss;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    bx    = (s ? ~bb : bb) & mask;
    full  = {1'b0, aa & mask} + {1'b0, bx} + 33'(s);
    sm    = full[31:0] & mask;
    sa    = aa[w-1];
    sb    = bx[w-1];
    ss    = sm[w-1];
    m.co  = full[w];
    m.ov  = (sa == sb) && (ss != sa);
    m.r   = (st && m.ov) ? (sa ? (32'h1 << (w - 1)) : (mask >> 1)) : sm;
    m.z   = (m.r == 32'h0);
    m.stamp   = cyc;
    m.chk_lat = lat_on;
    return m;
  endfunction

  function automatic void chk_out(string nm, logic [31:0] r, logic co, logic ov, logic z,
                                  exp_t e, int lat);
    cmp({nm, " result"}, r, e.r);
    cmp({nm, " flags"}, {29'h0, co, ov, z}, {29'h0, e.co, e.ov, e.z});
    if (e.chk_lat) cmp({nm, " latency"}, 32'(cyc - e.stamp), 32'(lat + 1));
    $display("%s out result=%0h cout=%b ovf=%b zero=%b", nm, r, co, ov, z);
  endfunction

  function automatic void none_expected(string nm, logic [31:0] r);
    n_cmp++;
    n_fail++;
    $display("FAIL %s unexpected: got result %0h, expected no output", nm, r);
  endfunction

  // Scoreboards: accept and retire are both judged half a cycle before the edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (in_valid && in_ready0) q0.push_back(model(8, a, b, sub, sat));
      if (in_valid && in_ready1) q1.push_back(model(32, a, b, sub, sat));
      if (in_valid && in_ready2) q2.push_back(model(8, a, b, sub, sat));
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) none_expected("sb0", 32'(result0));
        else chk_out("sb0", 32'(result0), cout0, overflow0, zero0, q0.pop_front(), 2);
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) none_expected("sb1", result1);
        else chk_out("sb1", result1, cout1, overflow1, zero1, q1.pop_front(), 4);
      end
      if (out_valid2 && out_ready) begin
        if (q2.size() == 0) none_expected("sb2", 32'(result2));
        else chk_out("sb2", 32'(result2), cout2, overflow2, zero2, q2.pop_front(), 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[10];
    int   lat;
    int   idx;
    bit   took;
    bit   prev_or;
    logic [7:0] hold_r;
    logic       hold_v;

    tab[0] = '{8'h3C, 8'h14, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0};
    tab[1] = '{8'h14, 8'h14, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tab[2] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    tab[3] = '{8'h70, 8'h20, 1'b0, 1'b0, 8'h90, 1'b0, 1'b1, 1'b0};
    tab[4] = '{8'h70, 8'h20, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    tab[5] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
    tab[6] = '{8'h90, 8'h90, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
    tab[7] = '{8'h7F, 8'h80, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    tab[8] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tab[9] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

    // Reset held with in_valid high: nothing captured, outputs cleared.
    in_valid = 1'b1;
    a = 32'h55;
    b = 32'h11;
    repeat (3) begin
      @(negedge clk);
      cmp("reset out_valid", 32'(out_valid0), 32'h0);
      cmp("reset result", 32'(result0), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmp("post-reset empty", 32'(out_valid0), 32'h0);
      cmp("post-reset in_ready", 32'(in_ready0), 32'h1);
    end

    // Table-driven single ops on the 8/2 instance.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a = 32'(tab[i].a);
      b = 32'(tab[i].b);
      sub = tab[i].sub;
      sat = tab[i].sat;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid0 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      cmp($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
      cmp($sformatf("vec%0d result", i), 32'(result0), 32'(tab[i].r));
      cmp($sformatf("vec%0d cout", i), 32'(cout0), 32'(tab[i].co));
      cmp($sformatf("vec%0d overflow", i), 32'(overflow0), 32'(tab[i].ov));
      cmp($sformatf("vec%0d zero", i), 32'(zero0), 32'(tab[i].z));
      $display("vec%0d a=%h b=%h sub=%b sat=%b -> result=%h cout=%b ovf=%b zero=%b",
               i, tab[i].a, tab[i].b, tab[i].sub, tab[i].sat, result0, cout0, overflow0, zero0);
    end
    repeat (4) @(posedge clk);

    // 20 back-to-back random ops on all three widths, latency checked per op.
    lat_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      sub = 1'($urandom_range(0, 1));
      sat = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat_on = 1'b0;
    repeat (8) @(negedge clk);
    cmp("stream drain sb0", 32'(q0.size()), 32'h0);
    cmp("stream drain sb1", 32'(q1.size()), 32'h0);
    cmp("stream drain sb2", 32'(q2.size()), 32'h0);

    // Backpressure: out_ready low for 3 cycles while in_valid stays asserted.
    idx = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    a = $urandom;
    b = $urandom;
    sub = 1'($urandom_range(0, 1));
    sat = 1'($urandom_range(0, 1));
    @(negedge clk);
    took = in_valid && in_ready0;
    prev_or = out_ready;
    hold_r = result0;
    hold_v = out_valid0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 10) begin
          a = $urandom;
          b = $urandom;
          sub = 1'($urandom_range(0, 1));
          sat = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = !(c >= 5 && c < 8);
      @(negedge clk);
      took = in_valid && in_ready0;
      if (!out_ready) cmp($sformatf("stall%0d in_ready", c), 32'(in_ready0), 32'h0);
      if (!prev_or) begin
        cmp($sformatf("stall%0d result stable", c), 32'(result0), 32'(hold_r));
        cmp($sformatf("stall%0d valid stable", c), 32'(out_valid0), 32'(hold_v));
      end
      prev_or = out_ready;
      hold_r = result0;
      hold_v = out_valid0;
    end
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    cmp("bp ops issued", 32'(idx), 32'd10);
    cmp("bp drain sb0", 32'(q0.size()), 32'h0);
    cmp("bp drain sb1", 32'(q1.size()), 32'h0);
    cmp("bp drain sb2", 32'(q2.size()), 32'h0);

    // Reset with two ops in flight: outputs drop at once, nothing emerges.
    @(posedge clk); #1;
    in_valid = 1'b1;
    a = 32'h0000_0012;
    b = 32'h0000_0034;
    sub = 1'b0;
    sat = 1'b0;
    @(posedge clk); #1;
    a = 32'h0000_0056;
    b = 32'h0000_0021;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp("pre-reset s1 valid", 32'(out_valid2), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async clr out_valid0", 32'(out_valid0), 32'h0);
    cmp("async clr out_valid1", 32'(out_valid1), 32'h0);
    cmp("async clr out_valid2", 32'(out_valid2), 32'h0);
    cmp("async clr result2", 32'(result2), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      cmp("flushed out_valid0", 32'(out_valid0), 32'h0);
      cmp("flushed out_valid1", 32'(out_valid1), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined two's-complement adder-subtractor; successor to the fixed 4-bit ripple add/sub.
- Splits a WIDTH-bit operation into STAGES carry-chained chunks, one chunk per cycle, so throughput is one op per clock at any width.
- Adds a valid/ready handshake with backpressure, signed overflow, zero flag and an optional per-op saturating mode.
- Sits between operand registers and the result bus of the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (chunks); CHUNK = WIDTH/STAGES; STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/mode valid this cycle
- in_ready  output  1  block accepts the operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B (B inverted, carry-in = 1)
- sat  input  1  1 = clamp the signed result on overflow
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- result  output  WIDTH  sum/difference (saturated if sat and overflow)
- cout  output  1  unsigned carry out; for sub, 1 = no borrow (A >= B unsigned)
- overflow  output  1  signed overflow of the unsaturated result
- zero  output  1  result == 0 (after saturation)

Behaviour:
- Reset (async assert, sync deassert by the clock edge): all stage valid bits, out_valid, result, cout, overflow and zero = 0. in_ready = 1 while rst_n is high and the pipeline is empty. Any in-flight ops are discarded.
- Handshake: a transfer occurs on an edge where valid && ready. The pipeline advances as a whole: adv = !out_valid || out_ready, and in_ready = adv.
- While stalled (adv = 0), every stage holds its contents and outputs stay stable. in_valid may be held high without the op being captured twice.
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of A and (B XOR {WIDTH{sub}}) with the carry registered from stage k-1. Stage 0 carry-in = sub.
- Unprocessed high chunks of A, B, sub and sat are carried forward in skew registers. Completed low result chunks are carried forward alongside.
- Latency: an op accepted at edge N appears on out_valid/result after edge N+STAGES, assuming no stall. Each stall cycle adds exactly one cycle.
- Throughput: one op per clock when out_ready is held high. Back-to-back ops must not corrupt each other's carries.
- Overflow: overflow = carry into MSB XOR carry out of MSB, computed in the final stage; cout = final carry out.
- Saturation: if sat && overflow, result = 0111..1 when the true result is positive (A MSB = 0), else 1000..0. cout and overflow report the unsaturated operation.
- Wrap-around: with sat = 0 the result is modulo 2^WIDTH.
- Simultaneous events:
  - out_ready with in_valid on a full pipeline: the output retires and the new op enters on the same edge.
  - in_valid while the pipeline is empty and the output is not valid: the op is accepted regardless of out_ready.
- Reset mid-operation: all valid bits clear immediately (async). No partial result is ever presented.
- STAGES = 1 degenerates to a single registered full-width add/sub with latency 1.

Decomposition:
- Shared package `add_sub_pkg`:
  - op-mode localparams ADD = 1'b0, SUB = 1'b1.
  - function `sat_value(width, negative)` returning the saturation constant.
  - CHUNK derivation helper.
- Natural sub-module `add_sub_chunk`: a combinational CHUNK-bit ripple adder (CHUNK full adders plus the B-XOR-mode inverters). It outputs sum, carry out and carry into its MSB. It is instantiated STAGES times under a generate loop.
- Registers, skew logic, handshake and flag logic stay in the top module.

Test Plan (WIDTH=8, STAGES=2 unless stated):
- Reset: hold rst_n = 0 with in_valid = 1 -> out_valid = 0, result = 0, no capture. Release -> first op accepted, out_valid after 2 edges.
- Add/sub basics:
  - a=0x3C, b=0x14, sub=0 -> result 0x50, cout 0, overflow 0, zero 0.
  - a=0x14, b=0x14, sub=1 -> 0x00, cout 1, zero 1.
  - a=0x10, b=0x20, sub=1 -> 0xF0, cout 0.
- Overflow/saturation:
  - a=0x70, b=0x20, sub=0, sat=0 -> 0x90, overflow 1.
  - Same op with sat=1 -> 0x7F, overflow 1.
  - a=0x80, b=0x01, sub=1, sat=1 -> 0x80, overflow 1.
  - a=0x90, b=0x90, sub=0, sat=1 -> 0x80, overflow 1, cout 1.
- Streaming: 20 back-to-back random ops with out_ready = 1 -> 20 results in order, 1 per clock, latency 2, all matching the reference model.
- Backpressure: drop out_ready for 3 cycles mid-stream -> in_ready = 0 for those cycles, outputs stable, no loss or duplication, order preserved.
- Mid-op reset and width sweep:
  - Assert rst_n low with 2 ops in flight -> out_valid = 0 immediately; neither op ever emerges.
  - Rerun the random streaming test with WIDTH=32, STAGES=4 and with WIDTH=8, STAGES=1.
